// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel-entry layout and writer state encoding
// for the plot-to-framebuffer path.
package fb_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
   localparam int ADDR_W    = 17;
   localparam int COLOUR_W  = 3;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [COLOUR_W-1:0] colour;
   } pix_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLOT  = 2'd1,
      CLEAR = 2'd2
   } fb_state_t;

   // y*320 + x using shifts only (320 = 256 + 64)
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] y, input logic [8:0] x);
      logic [ADDR_W-1:0] yw;
      yw = {{(ADDR_W-8){1'b0}}, y};
      return (yw << 8) + (yw << 6) + {{(ADDR_W-9){1'b0}}, x};
   endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; the head entry is always
// presented on dout so the consumer can use it without a read strobe.
module plot_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/plot_fb_writer.sv
// Accepts plot strobes, queues them as linear framebuffer writes and drains
// them over a valid/ready port; also runs a whole-frame fill on request.
module plot_fb_writer
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = FB_WIDTH,
   parameter int HEIGHT     = FB_HEIGHT
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [8:0]          plot_x,
   input  logic [7:0]          plot_y,
   input  logic [COLOUR_W-1:0] plot_colour,
   input  logic                plot,
   output logic                plot_ready,
   input  logic                clear_start,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                clear_done,
   output logic                busy,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [COLOUR_W-1:0] mem_wdata,
   output logic                mem_we,
   input  logic                mem_ready,
   output logic                overflow,
   output logic                oob
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [8:0] X_LIM = 9'(WIDTH);
   localparam logic [8:0] Y_LIM = 9'(HEIGHT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   fb_state_t           state, state_nxt;
   logic                clear_pending;
   logic [COLOUR_W-1:0] clr_colour;
   logic [ADDR_W-1:0]   clr_addr;
   logic                enter_clear;

   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   pix_entry_t          entry_in, head;

   logic accept, in_range, push, pop, clr_fire, clr_last;

   // mem port: mem_we is valid, mem_ready is ready; a write completes on a
   // rising edge where both are high, and addr/wdata/we hold until it does.
   assign plot_ready = !fifo_full && !clear_pending && (state != CLEAR);
   assign accept     = plot && plot_ready;
   assign in_range   = (plot_x < X_LIM) && ({1'b0, plot_y} < Y_LIM);
   assign push       = accept && in_range;
   assign pop        = (state == PLOT) && mem_ready;
   assign clr_fire   = (state == CLEAR) && mem_ready;
   assign clr_last   = clr_fire && (clr_addr == LAST_ADDR);
   assign busy       = !((state == IDLE) && fifo_empty && !clear_pending);
   assign entry_in   = '{addr: pix_addr(plot_y, plot_x), colour: plot_colour};

   plot_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(pix_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .din   (entry_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_nxt   = state;
      enter_clear = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (state)
         IDLE: begin
            if (push) begin
               state_nxt = PLOT;
            end else if (clear_pending) begin
               state_nxt   = CLEAR;
               enter_clear = 1'b1;
            end
         end
         PLOT: begin
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.colour;
            // last entry leaving with nothing arriving behind it
            if (pop && !push && (fifo_count == CNT_W'(1))) begin
               if (clear_pending) begin
                  state_nxt   = CLEAR;
                  enter_clear = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = clr_colour;
            if (clr_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         clear_pending <= 1'b0;
         clr_colour    <= '0;
         clr_addr      <= '0;
         clear_done    <= 1'b0;
         overflow      <= 1'b0;
         oob           <= 1'b0;
      end else begin
         state      <= state_nxt;
         clear_done <= clr_last;
         if (enter_clear) begin
            clear_pending <= 1'b0;
            clr_addr      <= '0;
         end else begin
            if (clear_start && (state != CLEAR)) begin
               clear_pending <= 1'b1;
               clr_colour    <= clear_colour;
            end
            if (clr_fire) clr_addr <= clr_addr + ADDR_W'(1);
         end
         if (plot && !plot_ready) overflow <= 1'b1;
         if (accept && !in_range) oob <= 1'b1;
      end
   end

endmodule

// File: doc/plot_fb_writer.md
# plot_fb_writer

- Sink for the pixel-plot stream produced by the fractal generator (`vga_x`, `vga_y`, `vga_colour`, `vga_plot`).
- Buffers plot requests and converts (x, y) to a linear framebuffer address, y·320 + x.
- Issues single-word writes to the external 320×240×3-bit framebuffer RAM over a valid/ready handshake.
- Provides a hardware clear that fills the whole framebuffer with one colour, and reports drop and out-of-range conditions.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: plot buffer entries (power of two, ≥2)
- `WIDTH`, 320: pixels per line
- `HEIGHT`, 240: lines per frame

Ports:
- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  reset; one clock, reset asynchronous active-low
- `plot_x`  in  9  pixel column
- `plot_y`  in  8  pixel row
- `plot_colour`  in  3  pixel colour
- `plot`  in  1  plot strobe, one pixel per cycle high
- `plot_ready`  out  1  a `plot` sampled high while this is high is accepted
- `clear_start`  in  1  single-cycle pulse that requests a framebuffer clear
- `clear_colour`  in  3  fill colour, sampled with `clear_start`
- `clear_done`  out  1  one-cycle pulse when the clear completes
- `busy`  out  1  high unless in IDLE with an empty FIFO and no pending clear
- `mem_addr`  out  17  framebuffer word address
- `mem_wdata`  out  3  write data
- `mem_we`  out  1  write valid
- `mem_ready`  in  1  RAM accepts the write this cycle
- `overflow`  out  1  sticky: a plot was dropped because `plot_ready` was low
- `oob`  out  1  sticky: a plot had x ≥ WIDTH or y ≥ HEIGHT

## Operation
- **States:**
  - IDLE: FIFO empty.
  - PLOT: FIFO non-empty, draining.
  - CLEAR: filling the framebuffer.
- **Push:**
  - A plot is accepted when `plot` && `plot_ready`.
  - If in range, the FIFO stores {addr = y·WIDTH + x (17 bits, computed at push), colour}.
  - If out of range, the plot is accepted but not stored, and `oob` is set.
- **Drop:** `plot` && !`plot_ready` → the pixel is discarded and `overflow` is set.
- **`plot_ready`** = !full && !clear_pending && state≠CLEAR.
  - Computed from registered state only; a simultaneous pop does not free a slot for that cycle's push.
- **Drain:**
  - In PLOT, `mem_we` = 1 and `mem_addr`/`mem_wdata` = FIFO head.
  - Pop on `mem_we` && `mem_ready`.
  - When the FIFO becomes empty: go to CLEAR if clear_pending, else IDLE.
  - IDLE → PLOT when the FIFO becomes non-empty.
- **Clear request:**
  - `clear_start` in any state other than CLEAR sets clear_pending and latches `clear_colour`.
  - `clear_start` during CLEAR is ignored.
  - CLEAR is entered from IDLE, or from PLOT once the FIFO empties; clear_pending is then cleared and the address counter is set to 0.
- **CLEAR:**
  - `mem_we` = 1, `mem_addr` = counter, `mem_wdata` = latched colour.
  - The counter increments on each accepted write.
  - The write at address WIDTH·HEIGHT−1 being accepted → `clear_done` pulses the next cycle and the state returns to IDLE.
- **Handshake rule:** while `mem_we` is high and `mem_ready` is low, `mem_addr`/`mem_wdata`/`mem_we` hold stable.
- **Sticky flags** clear only on reset.
- **Reset** (asynchronous, any time, including mid-clear):
  - state IDLE, FIFO empty, clear_pending 0.
  - `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
  - `plot_ready` 1, `busy` 0, `clear_done` 0, `overflow` 0, `oob` 0.
  - An interrupted clear is not resumed.

## Timing
- A plot accepted at edge N drives `mem_we` no earlier than cycle N+1.
- With `mem_ready` held high, drain throughput is one pixel per cycle.
- Push-to-write latency when the FIFO is empty is exactly 1 cycle.
- A clear with `mem_ready` held high takes 76800 write cycles.
  - `clear_done` is asserted in the cycle after the last handshake.
  - `busy` falls in that same cycle.
- A full FIFO drops `plot_ready` in the cycle after the push that filled it.

## Structure
- **Package `fb_pkg`:**
  - WIDTH, HEIGHT, FB_WORDS = 76800, ADDR_W = 17, COLOUR_W = 3.
  - Pixel-entry struct {addr, colour}.
  - State enum {IDLE, PLOT, CLEAR}.
- **Sub-module `plot_fifo`:**
  - Synchronous FIFO parameterised on depth and entry width.
  - Push/pop, full/empty, asynchronous active-low reset.
- The address multiply is implemented as (y<<8)+(y<<6)+x.

## Test plan
- **Single in-range plot:** reset, then plot (x=5, y=2, c=3), `mem_ready`=1 → next cycle `mem_we`=1, `mem_addr`=645, `mem_wdata`=3; `busy` falls after one write.
- **Back-pressure and drop:** `mem_ready`=0, 6 consecutive plots → 4 accepted, `plot_ready` low from the 5th cycle, `overflow`=1; release `mem_ready` → 4 writes in order, each held stable while stalled.
- **Out-of-range plot:** plot (x=320, y=0) and (x=0, y=240) → no memory write, `oob`=1, `plot_ready` stays 1.
- **Clear during drain:** 3 plots queued, then `clear_start` with colour 5 → the 3 plot writes complete first, then addresses 0..76799 are written with 5; `clear_done` pulses once; plots during the clear see `plot_ready`=0.
- **Last pixel:** plot (319, 239) → `mem_addr`=76799.
- **Reset mid-clear:** assert `rstn`=0 at clear address 1000 → all outputs return to reset values immediately, no further writes, and a fresh plot afterwards works normally.
